// File: rtl/taller_keys_in_if.sv
// rtl/taller_keys_in_if.sv - Avalon-MM register bus bundle for the taller_keys_in key port
interface taller_keys_in_if;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );
endinterface

// File: rtl/taller_keys_in.sv
// rtl/taller_keys_in.sv - debounced active-low key input port with edge capture and irq; debounce enabled by macro TALLER_KEYS_DEBOUNCE_EN
module taller_keys_in #(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic              clk,
   input  logic              reset_n,
   taller_keys_in_if.slave   bus,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam logic [2:0] ADDR_STABLE = 3'd0;
   localparam logic [2:0] ADDR_MASK   = 3'd2;
   localparam logic [2:0] ADDR_EDGE   = 3'd3;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] load;
   logic [WIDTH-1:0] press;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] irqmask;
   logic [WIDTH-1:0] edgecapture;
   logic             wr_en;
   logic             unused_bits;

   // two-flop synchronizer; idle level is released (all ones)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

`ifdef TALLER_KEYS_DEBOUNCE_EN
   // counter only has to reach DEBOUNCE_CYCLES-1, so clog2 bits never wrap first
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
      logic [CNT_W-1:0] cnt;

      // count consecutive cycles that the synchronized level disagrees with stable
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt <= '0;
         end else if (sync2[i] == stable[i]) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign load[i] = (sync2[i] != stable[i]) && (cnt == CNT_LAST);
   end

   assign unused_bits = ^bus.writedata;
`else
   // without debouncing the synchronized level is accepted every clock
   assign load        = '1;
   assign unused_bits = ^{bus.writedata, DEBOUNCE_CYCLES[0]};
`endif

   // a press is a 1->0 transition of stable happening this cycle
   assign press = stable & load & ~sync2;

   assign wr_en = bus.chipselect && !bus.write_n;
   assign clr   = (wr_en && bus.address == ADDR_EDGE) ? bus.writedata[WIDTH-1:0] : '0;

   // accepted key level register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stable <= '1;
      end else begin
         stable <= (stable & ~load) | (sync2 & load);
      end
   end

   // interrupt mask register, written at address 2
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irqmask <= '0;
      end else if (wr_en && bus.address == ADDR_MASK) begin
         irqmask <= bus.writedata[WIDTH-1:0];
      end
   end

   // sticky press capture; a new press beats a simultaneous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         edgecapture <= '0;
      end else begin
         edgecapture <= (edgecapture & ~clr) | press;
      end
   end

   assign irq = |(edgecapture & irqmask);

   // zero-wait-state read mux, unused addresses and upper bits read as zero
   always_comb begin
      bus.readdata = '0;
      case (bus.address)
         ADDR_STABLE: bus.readdata[WIDTH-1:0] = stable;
         ADDR_MASK:   bus.readdata[WIDTH-1:0] = irqmask;
         ADDR_EDGE:   bus.readdata[WIDTH-1:0] = edgecapture;
         default:     bus.readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_taller_keys_in.sv
// tb/tb_taller_keys_in.sv - randomized self-checking bench for taller_keys_in against a run-length key model
module tb_taller_keys_in;
   localparam int WIDTH = 4;
   localparam int DEB   = 8;
`ifdef TALLER_KEYS_DEBOUNCE_EN
   localparam int D_EFF = DEB;
`else
   localparam int D_EFF = 1;
`endif
   localparam int LAT = 2 + D_EFF;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [WIDTH-1:0] in_port = 4'hF;
   logic             irq;

   int total = 0;
   int bad = 0;

   taller_keys_in_if bus();

   taller_keys_in #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus),
      .in_port(in_port),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // reference model: each key flips once its delayed level has disagreed for D_EFF edges in a row
   logic [WIDTH-1:0] m_s1 = 4'hF;
   logic [WIDTH-1:0] m_s2 = 4'hF;
   logic [WIDTH-1:0] m_stable = 4'hF;
   logic [WIDTH-1:0] m_mask = 4'h0;
   logic [WIDTH-1:0] m_ec = 4'h0;
   logic [WIDTH-1:0] m_nxt;
   logic [WIDTH-1:0] m_clr;
   int               run [WIDTH];

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_s1 = '1; m_s2 = '1; m_stable = '1; m_mask = '0; m_ec = '0;
         for (int i = 0; i < WIDTH; i++) run[i] = 0;
      end else begin
         m_nxt = m_stable;
         for (int i = 0; i < WIDTH; i++) begin
            if (m_s2[i] !== m_stable[i]) begin
               run[i] = run[i] + 1;
               if (run[i] >= D_EFF) begin
                  m_nxt[i] = m_s2[i];
                  run[i] = 0;
               end
            end else begin
               run[i] = 0;
            end
         end
         m_clr = '0;
         if (bus.chipselect && !bus.write_n) begin
            if (bus.address == 3'd2) m_mask = bus.writedata[WIDTH-1:0];
            if (bus.address == 3'd3) m_clr = bus.writedata[WIDTH-1:0];
         end
         m_ec = (m_ec & ~m_clr) | (m_stable & ~m_nxt);
         m_stable = m_nxt;
         m_s2 = m_s1;
         m_s1 = in_port;
      end
   end

   function automatic logic [31:0] exp_rd(input logic [2:0] a);
      case (a)
         3'd0:    return {28'h0, m_stable};
         3'd2:    return {28'h0, m_mask};
         3'd3:    return {28'h0, m_ec};
         default: return 32'h0;
      endcase
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      bus.address = a;
      #1;
      d = bus.readdata;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset_n = 1'b0;
      tick(2);
      rd(3'd0, d);
      total++; if (d !== 32'hF) begin bad++; $display("FAIL reset_hold_stable got=%h exp=%h", d, 32'hF); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_hold_irq got=%b exp=0", irq); end
      @(negedge clk);
      reset_n = 1'b1;
      tick(1);
      rd(3'd0, d);
      total++; if (d !== 32'hF) begin bad++; $display("FAIL reset_stable got=%h exp=%h", d, 32'hF); end
      rd(3'd2, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", d); end
      rd(3'd3, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_edge got=%h exp=0", d); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", irq); end
   endtask

   task automatic test_press(input logic [3:0] pat, input logic [3:0] exp_ec);
      logic [31:0] d;
      int k;
      wr(3'd2, {28'h0, exp_ec});
      in_port = pat;
      k = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         rd(3'd0, d);
         if (d[3:0] == pat) begin k = n; break; end
      end
      total++; if (k != LAT) begin bad++; $display("FAIL press_latency got=%0d exp=%0d", k, LAT); end
      rd(3'd3, d);
      total++; if (d !== {28'h0, exp_ec}) begin bad++; $display("FAIL press_edge got=%h exp=%h", d, exp_ec); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL press_irq got=%b exp=1", irq); end
      in_port = 4'hF;
      tick(LAT + 2);
      wr(3'd3, 32'hF);
      rd(3'd3, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL press_clear got=%h exp=0", d); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL press_clear_irq got=%b exp=0", irq); end
   endtask

   task automatic test_glitch;
      logic [31:0] d;
      in_port = 4'hD;
      tick(5);
      in_port = 4'hF;
      tick(LAT + 4);
      rd(3'd0, d);
      total++; if (d !== exp_rd(3'd0)) begin bad++; $display("FAIL glitch_stable got=%h exp=%h", d, exp_rd(3'd0)); end
`ifdef TALLER_KEYS_DEBOUNCE_EN
      total++; if (d !== 32'hF) begin bad++; $display("FAIL glitch_stable_const got=%h exp=%h", d, 32'hF); end
`endif
      rd(3'd3, d);
      total++; if (d !== exp_rd(3'd3)) begin bad++; $display("FAIL glitch_edge got=%h exp=%h", d, exp_rd(3'd3)); end
      total++; if (irq !== |(m_ec & m_mask)) begin bad++; $display("FAIL glitch_irq got=%b exp=%b", irq, |(m_ec & m_mask)); end
      wr(3'd3, 32'hF);
   endtask

   task automatic test_collision;
      logic [31:0] d;
      wr(3'd2, 32'h1);
      in_port = 4'hE;
      tick(LAT + 1);
      in_port = 4'hF;
      tick(LAT + 1);
      rd(3'd3, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL coll_pre got=%h exp=%h", d, 32'h1); end
      in_port = 4'hE;
      tick(LAT - 1);
      bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 3'd3; bus.writedata = 32'h1;
      @(negedge clk);
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      rd(3'd0, d);
      total++; if (d !== 32'hE) begin bad++; $display("FAIL coll_stable got=%h exp=%h", d, 32'hE); end
      rd(3'd3, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL coll_set_wins got=%h exp=%h", d, 32'h1); end
      total++; if (d !== exp_rd(3'd3)) begin bad++; $display("FAIL coll_model got=%h exp=%h", d, exp_rd(3'd3)); end
      wr(3'd3, 32'h1);
      rd(3'd3, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL coll_cleared got=%h exp=0", d); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL coll_irq got=%b exp=0", irq); end
      in_port = 4'hF;
      tick(LAT + 1);
   endtask

   task automatic test_mask_release;
      logic [31:0] d;
      wr(3'd2, 32'h0);
      in_port = 4'hB;
      tick(LAT + 1);
      rd(3'd3, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL mask_edge got=%h exp=%h", d, 32'h4); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_off got=%b exp=0", irq); end
      wr(3'd2, 32'h4);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_on got=%b exp=1", irq); end
      in_port = 4'hF;
      tick(LAT + 1);
      rd(3'd0, d);
      total++; if (d !== 32'hF) begin bad++; $display("FAIL release_stable got=%h exp=%h", d, 32'hF); end
      rd(3'd3, d);
      total++; if (d !== 32'h4) begin bad++; $display("FAIL release_edge got=%h exp=%h", d, 32'h4); end
      wr(3'd3, 32'hF);
      wr(3'd2, 32'h0);
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      wr(3'd2, 32'hF);
      in_port = 4'h7;
      tick(LAT - 1);
      reset_n = 1'b0;
      in_port = 4'hF;
      tick(2);
      reset_n = 1'b1;
      tick(LAT + 3);
      rd(3'd0, d);
      total++; if (d !== 32'hF) begin bad++; $display("FAIL rmid_stable got=%h exp=%h", d, 32'hF); end
      rd(3'd3, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rmid_edge got=%h exp=0", d); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL rmid_irq got=%b exp=0", irq); end
   endtask

   task automatic test_random;
      logic [31:0] d;
      int hold;
      hold = 0;
      for (int c = 0; c < 500; c++) begin
         if (hold == 0) begin
            in_port = 4'($urandom);
            hold = $urandom_range(1, 2 * D_EFF + 3);
         end
         hold--;
         bus.address = 3'($urandom_range(0, 7));
         bus.writedata = $urandom;
         if ($urandom_range(0, 5) == 0) begin
            bus.chipselect = 1'b1; bus.write_n = 1'b0;
         end else begin
            bus.chipselect = 1'($urandom_range(0, 1)); bus.write_n = 1'b1;
         end
         #1;
         d = bus.readdata;
         total++; if (d !== exp_rd(bus.address)) begin bad++; $display("FAIL rand_read c=%0d a=%0d got=%h exp=%h", c, bus.address, d, exp_rd(bus.address)); end
         total++; if (irq !== |(m_ec & m_mask)) begin bad++; $display("FAIL rand_irq c=%0d got=%b exp=%b", c, irq, |(m_ec & m_mask)); end
         @(negedge clk);
      end
      bus.chipselect = 1'b0; bus.write_n = 1'b1;
      in_port = 4'hF;
      tick(LAT + 2);
      rd(3'd0, d);
      total++; if (d !== 32'hF) begin bad++; $display("FAIL rand_settle got=%h exp=%h", d, 32'hF); end
   endtask

   initial begin
      bus.address = 3'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'h0;
      test_reset();
      test_press(4'hE, 4'h1);
      test_glitch();
      test_collision();
      test_mask_release();
      test_press(4'h7, 4'h8);
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/taller_keys_in.md
TALLER_KEYS_IN -- requirements
Module: taller_keys_in

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, the number of key inputs.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz), the number of stable cycles needed to accept a new input level; legal range 2..2^20.
REQ-003 The block SHALL have port clk, input, 1, the system clock.
REQ-004 The block SHALL have port reset_n, input, 1, the reset; asynchronous, active-low.
REQ-005 The block SHALL have port address, input, 3, the Avalon-MM word address.
REQ-006 The block SHALL have port chipselect, input, 1, the Avalon-MM select.
REQ-007 The block SHALL have port write_n, input, 1, the Avalon-MM write strobe; active-low.
REQ-008 The block SHALL have port writedata, input, 32, the Avalon-MM write data.
REQ-009 The block SHALL have port in_port, input, WIDTH, the raw asynchronous key levels; active-low, 1 = released.
REQ-010 The block SHALL have port readdata, output, 32, the Avalon-MM read data.
REQ-011 The block SHALL have port irq, output, 1, the active-high interrupt request.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer (sync1, sync2) before any other use.
REQ-013 Each bit SHALL have a debounce counter: it resets to 0 when sync2 equals stable, and otherwise increments.
REQ-014 When a counter reaches DEBOUNCE_CYCLES-1 while sync2 differs from stable, the next edge SHALL load stable from sync2 and clear the counter.
REQ-015 A glitch shorter than DEBOUNCE_CYCLES clocks SHALL never change stable.
REQ-016 Register map (readdata combinational, zero wait states): address 0 = stable (read-only); address 2 = irqmask (read/write); address 3 = edgecapture (read; write-1-to-clear).
REQ-017 Reads of all other addresses SHALL return 0, and writes to them SHALL be ignored; readdata bits 31..WIDTH SHALL always be 0.
REQ-018 A write is valid only when chipselect=1 and write_n=0; irqmask SHALL load writedata[WIDTH-1:0] on a valid write to address 2.
REQ-019 edgecapture[i] SHALL set on the same edge on which stable[i] changes from 1 to 0 (key press), and SHALL hold until cleared.
REQ-020 A valid write to address 3 SHALL clear each edgecapture bit whose writedata bit is 1.
REQ-021 If a set and a clear hit the same bit in the same cycle, set SHALL win.
REQ-022 irq SHALL equal the OR-reduction of (edgecapture AND irqmask), combinational from registers.
REQ-023 Key release (stable 0->1) SHALL NOT set edgecapture.
REQ-024 The counter width SHALL be sized so that it cannot wrap before reaching DEBOUNCE_CYCLES-1.

Reset
REQ-025 While reset_n=0, sync1, sync2 and stable SHALL be all-ones, counters SHALL be 0, and irqmask and edgecapture SHALL be 0.
REQ-026 irq SHALL be 0 during reset, and readdata at address 0 SHALL read {WIDTH{1}}.
REQ-027 Reset asserted mid-debounce SHALL discard the pending change; no edge SHALL be captured for it after release.

Configuration
REQ-028 With macro TALLER_KEYS_DEBOUNCE_EN defined, debouncing SHALL operate per REQ-013..015.
REQ-029 Without TALLER_KEYS_DEBOUNCE_EN, no counters SHALL be built and stable SHALL load sync2 every clock, giving a 3-edge latency from in_port to stable; DEBOUNCE_CYCLES SHALL be ignored.

Verification (DEBOUNCE_CYCLES=8, WIDTH=4, macro defined unless noted)
REQ-030 Reset sanity: after reset release, read address 0 -> 0xF; addresses 2 and 3 -> 0x0; irq=0.
REQ-031 Press and interrupt: write 0x1 to address 2, then drive in_port=0xE steady -> stable reads 0xE exactly 2+8 edges later; address 3 reads 0x1; irq=1.
REQ-032 Glitch: drive in_port=0xD for 5 clocks, then return to 0xF -> address 0 stays 0xF; edgecapture=0; irq=0.
REQ-033 Clear and set collision: with edgecapture=0x1, write 0x1 to address 3 on the same cycle bit 0 sets again -> bit stays 1; a later write of 0x1 -> 0x0 and irq=0.
REQ-034 Mask and release: press key 2 with irqmask=0 -> edgecapture=0x4, irq=0; write irqmask=0x4 -> irq=1; release key 2 -> edgecapture unchanged.
REQ-035 Macro undefined: in_port 0xF->0x7 -> address 0 reads 0x7 on the 3rd edge; edgecapture=0x8.
